int_add_fu_ctrl: RTL and testbench

- Issue/sequencing controller for the shared 64-bit integer add/sub functional unit in the Tomasulo core.
- Arbitrates round-robin among reservation-station (RS) entries whose operands are ready.
- Drives the carry-lookahead adder through a 2-stage registered pipeline.
- Holds each result in an output register until the common data bus (CDB) accepts it.

---
 rtl/int_add_fu_ctrl.sv | 128 ++++++++++++
 tb/tb_int_add_fu_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_add_fu_ctrl.sv
// rtl/int_add_fu_ctrl.sv - round-robin issue and 2-stage pipeline controller for the shared integer add/sub unit
module int_add_fu_ctrl #(
  parameter int NUM_RS = 4,
  parameter int XLEN   = 64,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_RS-1:0]       req_valid,
  input  logic [NUM_RS-1:0]       req_op,
  input  logic [NUM_RS*XLEN-1:0]  req_a,
  input  logic [NUM_RS*XLEN-1:0]  req_b,
  input  logic [NUM_RS*TAG_W-1:0] req_tag,
  output logic [NUM_RS-1:0]       grant,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [XLEN-1:0]         cdb_data,
  output logic                    cdb_cout,
  output logic                    cdb_ovf,
  input  logic                    cdb_ack,
  output logic                    busy
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] cand;
  logic             sel_found;
  int               idx;

  logic             s1_valid;
  logic             s1_op;
  logic [XLEN-1:0]  s1_a;
  logic [XLEN-1:0]  s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [XLEN-1:0]  s2_data;
  logic             s2_cout;
  logic             s2_ovf;
  logic [TAG_W-1:0] s2_tag;

  logic s2_free, s1_adv, s1_free, grant_en;

  assign s2_free = ~s2_valid | cdb_ack;
  assign s1_adv  = s1_valid & s2_free;
  assign s1_free = ~s1_valid | s2_free;

  // Search upward from rr_ptr, wrapping, for the first ready entry
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < NUM_RS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_RS) idx = idx - NUM_RS;
      cand = PTR_W'(idx);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign grant_en = s1_free & ~flush & sel_found & ~rst;
  assign grant    = grant_en ? (NUM_RS'(1) << sel_idx) : '0;

  // Subtract is a + ~b + 1; cout is therefore NOT borrow for sub
  logic [XLEN-1:0] b_eff;
  logic [XLEN-1:0] sum;
  logic            cout;
  logic            ovf;

  assign b_eff       = s1_op ? ~s1_b : s1_b;
  assign {cout, sum} = {1'b0, s1_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, s1_op};
  assign ovf         = (s1_a[XLEN-1] == b_eff[XLEN-1]) & (sum[XLEN-1] != s1_a[XLEN-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_op    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_cout  <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (grant_en) begin
        s1_valid <= 1'b1;
        s1_op    <= req_op[sel_idx];
        s1_a     <= req_a[sel_idx*XLEN +: XLEN];
        s1_b     <= req_b[sel_idx*XLEN +: XLEN];
        s1_tag   <= req_tag[sel_idx*TAG_W +: TAG_W];
        rr_ptr   <= (sel_idx == PTR_W'(NUM_RS - 1)) ? '0 : sel_idx + 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      // S2 only reloads once its current result has been accepted, so cdb_* hold under backpressure
      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_data  <= sum;
        s2_cout  <= cout;
        s2_ovf   <= ovf;
        s2_tag   <= s1_tag;
      end else if (cdb_ack) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign cdb_valid = s2_valid;
  assign cdb_tag   = s2_tag;
  assign cdb_data  = s2_data;
  assign cdb_cout  = s2_cout;
  assign cdb_ovf   = s2_ovf;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_int_add_fu_ctrl.sv
// tb/tb_int_add_fu_ctrl.sv - self-checking bench for int_add_fu_ctrl with an in-order result scoreboard
module tb_int_add_fu_ctrl;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [3:0]   req_valid;
  logic [3:0]   req_op;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [15:0]  req_tag;
  logic [3:0]   grant;
  logic         cdb_valid;
  logic [3:0]   cdb_tag;
  logic [63:0]  cdb_data;
  logic         cdb_cout;
  logic         cdb_ovf;
  logic         cdb_ack;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic [63:0] data;
    logic        cout;
    logic        ovf;
    logic        at_out;
  } item_t;

  item_t q[$];
  int    rr = 0;

  int_add_fu_ctrl #(.NUM_RS(4), .XLEN(64), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .grant(grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_cout(cdb_cout), .cdb_ovf(cdb_ovf), .cdb_ack(cdb_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: true signed/unsigned results, not the adder structure
  function automatic item_t calc(input logic op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] tag);
    item_t r;
    logic signed [64:0] sa, sb, ss;
    logic [64:0] u;
    sa = $signed({a[63], a});
    sb = $signed({b[63], b});
    u  = {1'b0, a} + {1'b0, b};
    if (!op) begin
      ss     = sa + sb;
      r.cout = u[64];
    end else begin
      ss     = sa - sb;
      r.cout = (a >= b);
    end
    r.data   = ss[63:0];
    r.ovf    = (ss[64] != ss[63]);
    r.tag    = tag;
    r.at_out = 1'b0;
    return r;
  endfunction

  task automatic set_req(input int i, input logic op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag);
    req_op[i]          = op;
    req_a[i*64 +: 64]  = a;
    req_b[i*64 +: 64]  = b;
    req_tag[i*4 +: 4]  = tag;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Called at the negedge: check against the model, advance the model, step to posedge+1
  task automatic tick();
    logic [3:0] eg;
    int gi;
    logic ev;
    item_t it;
    eg = '0;
    gi = -1;
    if (!rst && !flush && (q.size() < 2 || cdb_ack))
      for (int k = 0; k < 4; k++)
        if (gi < 0 && req_valid[(rr + k) % 4]) gi = (rr + k) % 4;
    if (gi >= 0) eg[gi] = 1'b1;
    chk("grant", 64'(grant), 64'(eg));
    chk("busy", 64'(busy), 64'(q.size() > 0));
    ev = (q.size() > 0) && q[0].at_out;
    chk("cdb_valid", 64'(cdb_valid), 64'(ev));
    if (ev) begin
      chk("cdb_tag", 64'(cdb_tag), 64'(q[0].tag));
      chk("cdb_data", cdb_data, q[0].data);
      chk("cdb_cout", 64'(cdb_cout), 64'(q[0].cout));
      chk("cdb_ovf", 64'(cdb_ovf), 64'(q[0].ovf));
    end
    if (rst) begin
      q.delete();
      rr = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (ev && cdb_ack) void'(q.pop_front());
      if (q.size() > 0 && !q[0].at_out) begin
        it = q[0];
        it.at_out = 1'b1;
        q[0] = it;
      end
      if (gi >= 0) begin
        q.push_back(calc(req_op[gi], req_a[gi*64 +: 64], req_b[gi*64 +: 64], req_tag[gi*4 +: 4]));
        rr = (gi + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    rr = 0;
    look();
    tick();
    rst = 1'b0;
  endtask

  task automatic single(input int i, input logic op, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] tag, input logic [63:0] ed, input logic ec, input logic eo);
    req_valid = '0;
    req_valid[i] = 1'b1;
    set_req(i, op, a, b, tag);
    cdb_ack = 1'b1;
    look();
    chk("single_grant", 64'(grant), 64'(4'b0001 << i));
    tick();
    req_valid = '0;
    look();
    chk("single_s1_valid", 64'(cdb_valid), 64'd0);
    tick();
    look();
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag", 64'(cdb_tag), 64'(tag));
    chk("single_data", cdb_data, ed);
    chk("single_cout", 64'(cdb_cout), 64'(ec));
    chk("single_ovf", 64'(cdb_ovf), 64'(eo));
    tick();
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  item_t bp_exp;

  initial begin
    rst = 1'b1; flush = 1'b0; cdb_ack = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_cdb_data", cdb_data, 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed arithmetic cases
    single(0, 1'b0, 64'd9, 64'd5, 4'd3, 64'd14, 1'b0, 1'b0);
    single(1, 1'b1, 64'd5, 64'd9, 4'd4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    single(2, 1'b1, 64'd9, 64'd5, 4'd5, 64'd4, 1'b1, 1'b0);
    single(3, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd6, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Round-robin with all entries ready and ack held
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, i[0], 64'(100 + i), 64'(7 * i), 4'(8 + i));
    req_valid = 4'b1111;
    cdb_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) req_valid = '0;
      look();
      if (c < 5) chk("rr_grant", 64'(grant), 64'(4'b0001 << (c % 4)));
      if (c >= 2 && c < 7) begin
        chk("rr_valid", 64'(cdb_valid), 64'd1);
        chk("rr_tag", 64'(cdb_tag), 64'(8 + ((c - 2) % 4)));
      end
      tick();
    end

    // Backpressure: rr now points at entry 1
    for (int i = 0; i < 4; i++) set_req(i, 1'($urandom), rnd64(), rnd64(), 4'(8 + i));
    bp_exp = calc(req_op[1], req_a[64 +: 64], req_b[64 +: 64], 4'd9);
    req_valid = 4'b1111;
    cdb_ack = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) begin
        cdb_ack = 1'b1;
        req_valid = '0;
      end
      look();
      if (c == 0) chk("bp_grant0", 64'(grant), 64'b0010);
      if (c == 1) chk("bp_grant1", 64'(grant), 64'b0100);
      if (c >= 2 && c < 5) begin
        chk("bp_grant_stall", 64'(grant), 64'd0);
        chk("bp_hold_data", cdb_data, bp_exp.data);
        chk("bp_hold_tag", 64'(cdb_tag), 64'd9);
      end
      if (c == 6) chk("bp_drain_tag", 64'(cdb_tag), 64'd10);
      if (c == 7) chk("bp_empty", 64'(cdb_valid), 64'd0);
      tick();
    end

    // Flush with both stages full; rr now points at entry 3
    req_valid = 4'b1111;
    cdb_ack = 1'b1;
    look(); chk("fl_grant0", 64'(grant), 64'b1000); tick();
    look(); chk("fl_grant1", 64'(grant), 64'b0001); tick();
    flush = 1'b1;
    look(); chk("fl_grant_blocked", 64'(grant), 64'd0); tick();
    flush = 1'b0;
    req_valid = '0;
    look();
    chk("fl_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    tick();
    req_valid = 4'b1111;
    look(); chk("fl_rr_kept", 64'(grant), 64'b0010); tick();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin look(); tick(); end

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, 1'($urandom), rnd64(), rnd64(), 4'($urandom));
      req_valid = 4'($urandom);
      cdb_ack   = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      look();
      tick();
    end
    flush = 1'b0;

    // Async reset mid-stream
    req_valid = 4'b1111;
    cdb_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin look(); tick(); end
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_grant", 64'(grant), 64'd0);
    q.delete();
    rr = 0;
    look();
    tick();
    rst = 1'b0;
    cdb_ack = 1'b1;
    look(); chk("ar_first_grant", 64'(grant), 64'b0001); tick();
    look(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
